// File: rtl/minv_pkg.sv
// Shared definitions for the modular-inversion host sequencer.
package minv_pkg;

    localparam int WORDS = 8;   // 32-bit words per operand
    localparam int DW    = 32;  // datapath word width

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD_U,
        S_LOAD_P,
        S_CHECK,
        S_START,
        S_WAIT,
        S_READ,
        S_SEND,
        S_ABORT
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_EVEN_P  = 2'd1;
    localparam logic [1:0] ERR_ZERO_U  = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/minv_watchdog.sv
// Clearable, saturating cycle counter; flags when LIMIT-1 has been reached.
module minv_watchdog #(
    parameter int LIMIT = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int TW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [TW-1:0] cnt_q, cnt_d;

    // Next count: clear has priority; increment stops at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && (cnt_q != '1))
            cnt_d = cnt_q + TW'(1);
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign expired_o = (cnt_q == TW'(LIMIT - 1));

endmodule

// File: rtl/minv_host_seq.sv
// Host sequencer: streams U and P into the MINV engine, starts it, waits for
// completion and streams the 8 result words back out.
module minv_host_seq
    import minv_pkg::*;
#(
    parameter int TIMEOUT = 100000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          load_we,
    output logic          load_sel,
    output logic [2:0]    load_addr,
    output logic [DW-1:0] load_data,
    output logic          minv_en,
    input  logic          minv_rdy,
    output logic [2:0]    res_addr,
    input  logic [DW-1:0] res_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy,
    output logic          err,
    output logic [1:0]    err_code
);

    localparam logic [2:0] LAST = 3'(WORDS - 1);

    state_e        state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic          nz_q, nz_d;        // OR of all U words seen so far
    logic          p0_q, p0_d;        // bit 0 of P word 0 (oddness)
    logic          err_q, err_d;
    logic [1:0]    code_q, code_d;
    logic          cap_q, cap_d;      // result word already captured in this SEND
    logic [DW-1:0] data_q, data_d;
    logic          rdy_en_q;          // holds in_ready low through the reset cycle
    logic          we_q, sel_q;
    logic [2:0]    waddr_q;
    logic [DW-1:0] wdata_q;
    logic          accept;
    logic          wd_clr, wd_en, wd_exp;

    minv_watchdog #(.LIMIT(TIMEOUT)) u_wd (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (wd_clr),
        .en_i      (wd_en),
        .expired_o (wd_exp)
    );

    assign in_ready = rdy_en_q & (state_q inside {S_IDLE, S_LOAD_U, S_LOAD_P});
    assign accept   = in_valid & in_ready;

    // Next-state and datapath control for the whole operation.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        nz_d    = nz_q;
        p0_d    = p0_q;
        err_d   = err_q;
        code_d  = code_q;
        cap_d   = cap_q;
        data_d  = data_q;
        wd_clr  = 1'b0;
        wd_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    err_d   = 1'b0;
                    code_d  = ERR_NONE;
                    nz_d    = |in_data;
                    idx_d   = 3'd1;
                    state_d = S_LOAD_U;
                end
            end
            S_LOAD_U: begin
                if (accept) begin
                    nz_d  = nz_q | (|in_data);
                    idx_d = idx_q + 3'd1;
                    if (idx_q == LAST) state_d = S_LOAD_P;
                end
            end
            S_LOAD_P: begin
                if (accept) begin
                    if (idx_q == 3'd0) p0_d = in_data[0];
                    idx_d = idx_q + 3'd1;
                    if (idx_q == LAST) state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                // Even modulus takes precedence over a zero operand.
                if (!p0_q) begin
                    err_d   = 1'b1;
                    code_d  = ERR_EVEN_P;
                    state_d = S_ABORT;
                end else if (!nz_q) begin
                    err_d   = 1'b1;
                    code_d  = ERR_ZERO_U;
                    state_d = S_ABORT;
                end else begin
                    state_d = S_START;
                end
            end
            S_START: begin
                wd_clr  = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wd_en = 1'b1;
                // Completion beats a coincident timeout.
                if (minv_rdy) begin
                    idx_d   = 3'd0;
                    state_d = S_READ;
                end else if (wd_exp) begin
                    err_d   = 1'b1;
                    code_d  = ERR_TIMEOUT;
                    state_d = S_ABORT;
                end
            end
            S_READ: begin
                cap_d   = 1'b0;
                state_d = S_SEND;
            end
            S_SEND: begin
                // Result RAM output is only valid in the first SEND cycle, so
                // latch it there and serve the copy while stalled.
                if (!cap_q) begin
                    data_d = res_data;
                    cap_d  = 1'b1;
                end
                if (out_ready) begin
                    cap_d = 1'b0;
                    if (idx_q == LAST) begin
                        idx_d   = 3'd0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_READ;
                    end
                end
            end
            S_ABORT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control/status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            nz_q     <= 1'b0;
            p0_q     <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= ERR_NONE;
            cap_q    <= 1'b0;
            data_q   <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            nz_q     <= nz_d;
            p0_q     <= p0_d;
            err_q    <= err_d;
            code_q   <= code_d;
            cap_q    <= cap_d;
            data_q   <= data_d;
            rdy_en_q <= 1'b1;
        end
    end

    // Each accepted operand beat becomes an engine register write one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            sel_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            we_q <= accept;
            if (accept) begin
                sel_q   <= (state_q == S_LOAD_P);
                waddr_q <= (state_q == S_IDLE) ? 3'd0 : idx_q;
                wdata_q <= in_data;
            end
        end
    end

    assign load_we   = we_q;
    assign load_sel  = sel_q;
    assign load_addr = waddr_q;
    assign load_data = wdata_q;
    assign minv_en   = (state_q == S_START);
    assign res_addr  = (state_q == S_READ) ? idx_q : 3'd0;
    assign out_valid = (state_q == S_SEND);
    assign out_data  = (out_valid && !cap_q) ? res_data : data_q;
    assign out_last  = out_valid && (idx_q == LAST);
    assign busy      = (state_q != S_IDLE);
    assign err       = err_q;
    assign err_code  = code_q;

endmodule

// File: tb/tb_minv_host_seq.sv
// Scoreboard bench for minv_host_seq with a stub MINV engine.
module tb_minv_host_seq;
    import minv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        load_we, load_sel;
    logic [2:0]  load_addr;
    logic [31:0] load_data;
    logic        minv_en, minv_rdy;
    logic [2:0]  res_addr;
    logic [31:0] res_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_last, busy, err;
    logic [1:0]  err_code;

    always #5 clk = ~clk;

    minv_host_seq #(.TIMEOUT(100)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .load_we(load_we), .load_sel(load_sel), .load_addr(load_addr), .load_data(load_data),
        .minv_en(minv_en), .minv_rdy(minv_rdy),
        .res_addr(res_addr), .res_data(res_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .err(err), .err_code(err_code)
    );

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // ---------------- stub engine ----------------
    logic [31:0] res_mem [8];
    int          rdy_delay = 40;   // cycles from minv_en to minv_rdy; <0 = never
    int          cd = -1;
    logic        rdy_q = 1'b0;
    logic        rdy_poke = 1'b0;
    int          cyc = 0;

    assign minv_rdy = rdy_q | rdy_poke;

    always @(posedge clk) begin
        rdy_q    <= 1'b0;
        res_data <= res_mem[res_addr];
        cyc      <= cyc + 1;
        if (rst)
            cd <= -1;
        else if (minv_en)
            cd <= (rdy_delay < 0) ? -1 : rdy_delay - 1;
        else if (cd == 1) begin
            rdy_q <= 1'b1;
            cd    <= -1;
        end else if (cd > 1)
            cd <= cd - 1;
    end

    // ---------------- scoreboard monitor ----------------
    logic [35:0] wq[$];   // {sel, addr, data}
    logic [32:0] oq[$];   // {last, data}
    int          en_cnt = 0;
    int          en_cyc = 0;
    int          nout = 0;
    logic        hold_v = 1'b0;
    logic [32:0] hold_val = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) hold_v = 1'b0;
            else begin
                if (load_we) begin
                    if (wq.size() == 0) chk("load_q", 64'(wq.size()), 64'd1);
                    else chk("load", {load_sel, load_addr, load_data}, wq.pop_front());
                end
                if (minv_en) begin
                    en_cnt++;
                    en_cyc = cyc;
                end
                if (out_valid) begin
                    if (hold_v) chk("hold", {out_last, out_data}, hold_val);
                    if (out_ready) begin
                        hold_v = 1'b0;
                        if (oq.size() == 0) chk("out_q", 64'(oq.size()), 64'd1);
                        else chk("out", {out_last, out_data}, oq.pop_front());
                        nout++;
                    end else begin
                        hold_v   = 1'b1;
                        hold_val = {out_last, out_data};
                    end
                end else hold_v = 1'b0;
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        rdy_poke = 1'b0;
        @(posedge clk); #1;
        chk("rst_ctl", {in_ready, load_we, load_sel, load_addr, minv_en, res_addr,
                        out_valid, out_last, busy, err, err_code}, 64'd0);
        chk("rst_dat", {load_data, out_data}, 64'd0);
        rst = 1'b0;
        wq.delete();
        oq.delete();
        @(posedge clk); #1;
        chk("rst_rdy", 64'(in_ready), 64'd1);
    endtask

    task automatic drive_op(input logic [255:0] u, input logic [255:0] p, input int poke_beat);
        logic [31:0] w;
        int n;
        for (int i = 0; i < 16; i++) begin
            w = (i < 8) ? u[32*i +: 32] : p[32*(i-8) +: 32];
            in_valid = 1'b1;
            in_data  = w;
            rdy_poke = (i == poke_beat);
            n = 0;
            @(negedge clk);
            while (!in_ready && n < 50) begin
                n++;
                @(negedge clk);
            end
            if (!in_ready) chk("in_ready_wait", 64'(in_ready), 64'd1);
            else wq.push_back({(i >= 8), 3'(i % 8), w});
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rdy_poke = 1'b0;
    endtask

    task automatic push_res();
        for (int k = 0; k < 8; k++) oq.push_back({(k == 7), res_mem[k]});
    endtask

    task automatic wait_idle(input int stall_idx);
        int n = 0;
        int stall = 10;
        forever begin
            @(posedge clk); #1;
            out_ready = 1'b1;
            if (out_valid && nout == stall_idx && stall > 0) begin
                out_ready = 1'b0;
                stall--;
            end
            if (!busy) break;
            n++;
            if (n > 600) begin
                chk("idle_wait", 64'(busy), 64'd0);
                break;
            end
        end
        out_ready = 1'b1;
    endtask

    task automatic check_run(input string tag, input int en0, input int exp_en,
                             input logic exp_err, input logic [1:0] exp_code);
        chk({tag, "_en"}, 64'(en_cnt - en0), 64'(exp_en));
        chk({tag, "_err"}, {err, err_code}, {exp_err, exp_code});
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_oq"}, 64'(oq.size()), 64'd0);
        chk({tag, "_wq"}, 64'(wq.size()), 64'd0);
    endtask

    task automatic normal_run(input string tag, input int stall_idx, input int poke);
        int e0 = en_cnt;
        nout = 0;
        push_res();
        drive_op(256'd3, 256'd7, poke);
        wait_idle(stall_idx);
        check_run(tag, e0, 1, 1'b0, ERR_NONE);
    endtask

    task automatic abort_run(input string tag, input logic [255:0] u, input logic [255:0] p,
                             input logic [1:0] code);
        int e0 = en_cnt;
        drive_op(u, p, -1);
        wait_idle(-1);
        check_run(tag, e0, 0, 1'b1, code);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        int e0;
        res_mem = '{32'd5, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        do_reset();

        normal_run("norm", -1, -1);

        res_mem = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66, 32'h77, 32'h88};
        normal_run("bp", 3, -1);

        abort_run("even", 256'd3, 256'd8, ERR_EVEN_P);
        abort_run("zero", 256'd0, 256'd7, ERR_ZERO_U);
        abort_run("both", 256'd0, 256'd8, ERR_EVEN_P);

        res_mem = '{32'd5, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        normal_run("poke", -1, 10);

        // engine never answers
        rdy_delay = -1;
        e0 = en_cnt;
        drive_op(256'd3, 256'd7, -1);
        n = 0;
        @(negedge clk);
        while (!err && n < 400) begin
            n++;
            @(negedge clk);
        end
        chk("to_lat", 64'(cyc - en_cyc), 64'd101);
        wait_idle(-1);
        check_run("to", e0, 1, 1'b1, ERR_TIMEOUT);

        rdy_delay = 40;
        normal_run("clr", -1, -1);

        // completion lands on the same cycle as the timeout
        rdy_delay = 100;
        res_mem = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5, 32'hA6, 32'hA7};
        normal_run("coll", -1, -1);

        // reset while waiting for the engine
        rdy_delay = 40;
        drive_op(256'd3, 256'd7, -1);
        repeat (10) begin
            @(posedge clk); #1;
        end
        chk("wait_busy", {busy, out_valid}, 2'b10);
        do_reset();
        normal_run("post_wait", -1, -1);

        // reset while presenting a result word
        push_res();
        drive_op(256'd3, 256'd7, -1);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!out_valid && n < 200);
        chk("send_seen", 64'(out_valid), 64'd1);
        do_reset();
        normal_run("post_send", -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
